// File: rtl/d1fifo_pkg.sv
// d1fifo_pkg: shared width helpers and the per-channel status bundle for the
// multi-channel registered-read FIFO bank.
package d1fifo_pkg;

    // Occupancy counter width: must represent 0..size inclusive.
    function automatic int cnt_w(input int size);
        return $clog2(size + 1);
    endfunction

    // Pointer width: addresses 0..size-1, never narrower than one bit.
    function automatic int ptr_w(input int size);
        return ($clog2(size) < 1) ? 1 : $clog2(size);
    endfunction

    // Per-channel flags, gathered so the top level only has to unpack them.
    typedef struct packed {
        logic full;
        logic empty;
        logic al_full;
        logic al_empty;
        logic overflow;
        logic underflow;
    } ch_status_t;

endpackage

// File: rtl/d1fifo_ch.sv
// d1fifo_ch: single-channel FIFO with registered read port, synchronous
// flush, programmable almost-full/almost-empty thresholds and sticky
// overflow/underflow flags. SIZE need not be a power of two.
module d1fifo_ch
    import d1fifo_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SIZE        = 32,
    parameter int AL_FULL_TH  = SIZE - 2,
    parameter int AL_EMPTY_TH = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic                      valid,
    output logic [cnt_w(SIZE)-1:0]    count,
    output ch_status_t                status
);

    localparam int CW = cnt_w(SIZE);
    localparam int PW = ptr_w(SIZE);
    localparam logic [CW-1:0] LP_SIZE = CW'(SIZE);
    localparam logic [PW-1:0] LP_LAST = PW'(SIZE - 1);

    logic [WIDTH-1:0] r_mem [SIZE];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rdata;
    logic             r_valid;
    logic             r_ovf;
    logic             r_udf;

    logic             w_full;
    logic             w_empty;
    logic             w_pop_acc;
    logic             w_push_acc;
    logic             w_ovf_evt;
    logic             w_udf_evt;
    logic [CW-1:0]    w_count_nxt;

    // Explicit wrap so non-power-of-two depths cycle through 0..SIZE-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LP_LAST) ? '0 : p + PW'(1);
    endfunction

    assign w_full  = (r_count == LP_SIZE);
    assign w_empty = (r_count == '0);

    // Flush overrides everything; a pop frees a slot, so a push at full is
    // still accepted when paired with a pop. Pop never falls through an
    // empty FIFO, even with a concurrent push.
    assign w_pop_acc  = !flush && pop && !w_empty;
    assign w_push_acc = !flush && push && (!w_full || w_pop_acc);
    assign w_ovf_evt  = !flush && push && w_full && !w_pop_acc;
    assign w_udf_evt  = !flush && pop && w_empty;

    // Next occupancy: push and pop together leave the count unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push_acc && !w_pop_acc) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop_acc && !w_push_acc) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Storage array, deliberately not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy, read register and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_valid <= w_pop_acc;
            // Read uses the pre-edge array value, so at full with push+pop
            // (wr_ptr == rd_ptr) the old entry is returned.
            if (w_pop_acc) begin
                r_rdata  <= r_mem[r_rd_ptr];
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push_acc) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            r_count <= w_count_nxt;
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end
            if (w_udf_evt) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign rdata = r_rdata;
    assign valid = r_valid;
    assign count = r_count;

    assign status.full      = w_full;
    assign status.empty     = w_empty;
    assign status.al_full   = int'(r_count) >= AL_FULL_TH;
    assign status.al_empty  = int'(r_count) <= AL_EMPTY_TH;
    assign status.overflow  = r_ovf;
    assign status.underflow = r_udf;

endmodule

// File: rtl/d1fifo_mc.sv
// d1fifo_mc: bank of NCH independent registered-read FIFOs. This level only
// slices the packed input vectors per channel and packs the results back.
module d1fifo_mc
    import d1fifo_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SIZE        = 32,
    parameter int NCH         = 4,
    parameter int AL_FULL_TH  = SIZE - 2,
    parameter int AL_EMPTY_TH = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NCH-1:0]                push,
    input  logic [NCH-1:0]                pop,
    input  logic [NCH-1:0]                flush,
    input  logic [NCH*WIDTH-1:0]          wdata,
    output logic [NCH*WIDTH-1:0]          rdata,
    output logic [NCH-1:0]                valid,
    output logic [NCH-1:0]                full,
    output logic [NCH-1:0]                empty,
    output logic [NCH-1:0]                al_full,
    output logic [NCH-1:0]                al_empty,
    output logic [NCH*cnt_w(SIZE)-1:0]    count,
    output logic [NCH-1:0]                overflow,
    output logic [NCH-1:0]                underflow
);

    localparam int CW = cnt_w(SIZE);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        ch_status_t w_status;

        d1fifo_ch #(
            .WIDTH       (WIDTH),
            .SIZE        (SIZE),
            .AL_FULL_TH  (AL_FULL_TH),
            .AL_EMPTY_TH (AL_EMPTY_TH)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .push   (push[c]),
            .pop    (pop[c]),
            .flush  (flush[c]),
            .wdata  (wdata[c*WIDTH +: WIDTH]),
            .rdata  (rdata[c*WIDTH +: WIDTH]),
            .valid  (valid[c]),
            .count  (count[c*CW +: CW]),
            .status (w_status)
        );

        assign full[c]      = w_status.full;
        assign empty[c]     = w_status.empty;
        assign al_full[c]   = w_status.al_full;
        assign al_empty[c]  = w_status.al_empty;
        assign overflow[c]  = w_status.overflow;
        assign underflow[c] = w_status.underflow;
    end

endmodule

// File: tb/tb_d1fifo_mc.sv
// tb_d1fifo_mc: directed bench for the FIFO bank. One 4x32x16 instance for
// the channel scenarios and a 1x5x8 instance for non-power-of-two wrap.
module tb_d1fifo_mc;
    import d1fifo_pkg::*;

    localparam int W  = 16;
    localparam int S  = 32;
    localparam int N  = 4;
    localparam int CW = 6;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     push  = '0;
    logic [N-1:0]     pop   = '0;
    logic [N-1:0]     flush = '0;
    logic [N*W-1:0]   wdata = '0;
    logic [N*W-1:0]   rdata;
    logic [N-1:0]     valid, full, empty, al_full, al_empty, overflow, underflow;
    logic [N*CW-1:0]  count;

    logic             b_push  = 1'b0;
    logic             b_pop   = 1'b0;
    logic             b_flush = 1'b0;
    logic [7:0]       b_wdata = '0;
    logic [7:0]       b_rdata;
    logic             b_valid, b_full, b_empty, b_al_full, b_al_empty, b_overflow, b_underflow;
    logic [2:0]       b_count;

    int checks = 0;
    int errors = 0;

    d1fifo_mc #(.WIDTH(W), .SIZE(S), .NCH(N)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
        .wdata(wdata), .rdata(rdata), .valid(valid), .full(full), .empty(empty),
        .al_full(al_full), .al_empty(al_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    d1fifo_mc #(.WIDTH(8), .SIZE(5), .NCH(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .push(b_push), .pop(b_pop), .flush(b_flush),
        .wdata(b_wdata), .rdata(b_rdata), .valid(b_valid), .full(b_full), .empty(b_empty),
        .al_full(b_al_full), .al_empty(b_al_empty), .count(b_count),
        .overflow(b_overflow), .underflow(b_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wd(input int c, input logic [W-1:0] v);
        wdata[c*W +: W] = v;
    endtask

    function automatic logic [W-1:0] rd(input int c);
        return rdata[c*W +: W];
    endfunction

    function automatic logic [CW-1:0] cnt(input int c);
        return count[c*CW +: CW];
    endfunction

    logic [7:0] q[$];
    logic [7:0] exp_b;
    logic       pa, pu;

    initial begin
        // Reset state (reset held across the first edge)
        #11;
        chk("rst_empty", empty, 4'hF);
        chk("rst_full", full, 4'h0);
        chk("rst_al_full", al_full, 4'h0);
        chk("rst_al_empty", al_empty, 4'hF);
        chk("rst_count", count, '0);
        chk("rst_valid", valid, 4'h0);
        chk("rst_rdata", rdata, '0);
        chk("rst_ovf", overflow, 4'h0);
        chk("rst_udf", underflow, 4'h0);
        chk("rst_b_empty", b_empty, 1'b1);
        rst_n = 1'b1;

        // Fill ch0 with 0..31
        for (int i = 0; i < 32; i++) begin
            push[0] = 1'b1;
            set_wd(0, W'(i));
            tick();
            chk($sformatf("fill0_cnt%0d", i), cnt(0), i + 1);
            chk($sformatf("fill0_alf%0d", i), al_full[0], (i + 1) >= 30);
        end
        push = '0;
        chk("fill0_full", full[0], 1'b1);
        chk("fill0_empty", empty[0], 1'b0);
        for (int c = 1; c < N; c++) begin
            chk($sformatf("fill0_other_cnt%0d", c), cnt(c), 0);
            chk($sformatf("fill0_other_empty%0d", c), empty[c], 1'b1);
        end

        // Drain ch0 in order
        for (int i = 0; i < 32; i++) begin
            pop[0] = 1'b1;
            tick();
            chk($sformatf("drain0_vld%0d", i), valid[0], 1'b1);
            chk($sformatf("drain0_data%0d", i), rd(0), i);
            chk($sformatf("drain0_cnt%0d", i), cnt(0), 31 - i);
            chk($sformatf("drain0_ale%0d", i), al_empty[0], (31 - i) <= 1);
        end
        pop = '0;
        tick();
        chk("drain0_vld_end", valid[0], 1'b0);
        chk("drain0_hold", rd(0), 31);
        chk("drain0_empty", empty[0], 1'b1);

        // Empty ch0 with push+pop: pop rejected, push accepted
        push[0] = 1'b1;
        pop[0]  = 1'b1;
        set_wd(0, 16'h5555);
        tick();
        push = '0;
        pop  = '0;
        chk("emptypp_udf", underflow[0], 1'b1);
        chk("emptypp_vld", valid[0], 1'b0);
        chk("emptypp_cnt", cnt(0), 1);
        flush[0] = 1'b1;
        tick();
        flush = '0;
        chk("emptypp_flush_udf", underflow[0], 1'b0);
        chk("emptypp_flush_cnt", cnt(0), 0);

        // ch1: push+pop while full returns oldest entry
        for (int i = 0; i < 32; i++) begin
            push[1] = 1'b1;
            set_wd(1, 16'h0100 + W'(i));
            tick();
        end
        push[1] = 1'b1;
        pop[1]  = 1'b1;
        set_wd(1, 16'hAAAA);
        tick();
        push = '0;
        pop  = '0;
        chk("fullpp_data", rd(1), 16'h0100);
        chk("fullpp_vld", valid[1], 1'b1);
        chk("fullpp_cnt", cnt(1), 32);
        chk("fullpp_full", full[1], 1'b1);
        chk("fullpp_ovf", overflow[1], 1'b0);
        for (int i = 0; i < 32; i++) begin
            pop[1] = 1'b1;
            tick();
            chk($sformatf("fullpp_drain%0d", i), rd(1), (i < 31) ? (16'h0101 + i) : 16'hAAAA);
        end
        pop = '0;
        tick();
        chk("fullpp_empty", empty[1], 1'b1);

        // ch2: underflow, then overflow, both sticky until flush
        pop[2] = 1'b1;
        tick();
        pop = '0;
        chk("err_udf", underflow[2], 1'b1);
        chk("err_udf_vld", valid[2], 1'b0);
        for (int i = 0; i < 32; i++) begin
            push[2] = 1'b1;
            set_wd(2, W'(i + 16'h0200));
            tick();
        end
        push[2] = 1'b1;
        set_wd(2, 16'hBEEF);
        tick();
        push = '0;
        chk("err_ovf", overflow[2], 1'b1);
        chk("err_ovf_cnt", cnt(2), 32);
        chk("err_udf_sticky", underflow[2], 1'b1);
        tick();
        chk("err_ovf_sticky", overflow[2], 1'b1);
        chk("err_other_ovf", overflow[1:0], 2'b00);
        flush[2] = 1'b1;
        tick();
        flush = '0;
        chk("err_flush_ovf", overflow[2], 1'b0);
        chk("err_flush_udf", underflow[2], 1'b0);
        chk("err_flush_cnt", cnt(2), 0);
        chk("err_flush_empty", empty[2], 1'b1);

        // ch3: flush beats concurrent push and pop
        for (int i = 0; i < 6; i++) begin
            push[3] = 1'b1;
            set_wd(3, W'(16'h0300 + i));
            tick();
        end
        push = '0;
        pop[3] = 1'b1;
        tick();
        chk("flp_pre_vld", valid[3], 1'b1);
        chk("flp_pre_cnt", cnt(3), 5);
        flush[3] = 1'b1;
        push[3]  = 1'b1;
        tick();
        flush = '0;
        push  = '0;
        pop   = '0;
        chk("flp_cnt", cnt(3), 0);
        chk("flp_vld", valid[3], 1'b0);
        chk("flp_empty", empty[3], 1'b1);
        chk("flp_ovf", overflow[3], 1'b0);
        chk("flp_udf", underflow[3], 1'b0);

        // SIZE=5 instance: 3 pushes / 2 pops per 5 cycles against a queue
        for (int i = 0; i < 20; i++) begin
            b_push  = (i % 5) <= 2;
            b_pop   = ((i % 5) == 2) || ((i % 5) == 3);
            b_wdata = 8'(8'h30 + i);
            pa = b_pop && (q.size() > 0);
            pu = b_push && ((q.size() < 5) || pa);
            if (pa) exp_b = q.pop_front();
            if (pu) q.push_back(b_wdata);
            tick();
            chk($sformatf("wrap_vld%0d", i), b_valid, pa);
            if (pa) chk($sformatf("wrap_data%0d", i), b_rdata, exp_b);
            chk($sformatf("wrap_cnt%0d", i), b_count, q.size());
        end
        b_push = 1'b0;
        for (int k = 0; k < 6; k++) begin
            b_pop = 1'b1;
            pa = (q.size() > 0);
            if (pa) exp_b = q.pop_front();
            tick();
            chk($sformatf("wrapdr_vld%0d", k), b_valid, pa);
            if (pa) chk($sformatf("wrapdr_data%0d", k), b_rdata, exp_b);
        end
        b_pop = 1'b0;
        chk("wrap_end_empty", b_empty, 1'b1);
        chk("wrap_end_udf", b_underflow, 1'b1);
        chk("wrap_end_ovf", b_overflow, 1'b0);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) begin
            push[1:0] = 2'b11;
            set_wd(0, W'(16'h0700 + i));
            set_wd(1, W'(16'h0800 + i));
            tick();
        end
        push = '0;
        pop[0] = 1'b1;
        tick();
        pop = '0;
        chk("arst_pre_vld", valid[0], 1'b1);
        chk("arst_pre_cnt", cnt(1), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, '0);
        chk("arst_valid", valid, 4'h0);
        chk("arst_empty", empty, 4'hF);
        chk("arst_rdata", rdata, '0);
        chk("arst_b_underflow", b_underflow, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("arst_post_empty", empty, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
